// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with programmable memory latency.
// Strobes are one-cycle Moore outputs; selects are levels decoded from the latched instruction.
module multicycle_control #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        negative,
    input  logic        overflow,
    input  logic        zero,
    input  logic        carry_out,
    input  logic        zero_alu,
    input  logic        stall,
    output logic [2:0]  aluop,
    output logic        reg2loc,
    output logic        alusrc,
    output logic        addi,
    output logic        byteop,
    output logic        mov,
    output logic        movk,
    output logic        mem2reg,
    output logic        uncondbr,
    output logic        regwr,
    output logic        memwr,
    output logic        setflags,
    output logic        setzeroflag,
    output logic        brtaken,
    output logic        pcwr,
    output logic        irwr,
    output logic        memrd,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;
    localparam logic [2:0] StHalt   = 3'd7;

    localparam logic [3:0] CntLast = 4'(MEM_LAT - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        illegal_q, illegal_d;
    logic [31:0] retired_q, retired_d;

    logic op_b, op_bcond, op_cbz, op_addi, op_adds, op_subs;
    logic op_ldur, op_stur, op_ldurb, op_sturb, op_movz, op_movk;
    logic is_load, is_store, is_mem, is_branch, is_legal, cond_true;
    logic cnt_last, sel_en, active;

    logic pcwr_raw, irwr_raw, regwr_raw, memwr_raw, setflags_raw, brtaken_raw, memrd_raw;

    logic unused_inputs;
    assign unused_inputs = ^{carry_out, instruction[20:5]};

    always_comb begin
        op_b      = (instruction[31:26] == 6'b000101);
        op_bcond  = (instruction[31:24] == 8'b01010100);
        op_cbz    = (instruction[31:24] == 8'b10110100);
        op_addi   = (instruction[31:22] == 10'b1001000100);
        op_adds   = (instruction[31:21] == 11'b10101011000);
        op_subs   = (instruction[31:21] == 11'b11101011000);
        op_ldur   = (instruction[31:21] == 11'b11111000010);
        op_stur   = (instruction[31:21] == 11'b11111000000);
        op_ldurb  = (instruction[31:21] == 11'b00111000010);
        op_sturb  = (instruction[31:21] == 11'b00111000000);
        op_movz   = (instruction[31:23] == 9'b110100101);
        op_movk   = (instruction[31:23] == 9'b111100101);
        is_load   = op_ldur | op_ldurb;
        is_store  = op_stur | op_sturb;
        is_mem    = is_load | is_store;
        is_branch = op_b | op_bcond | op_cbz;
        is_legal  = is_branch | is_mem | op_addi | op_adds | op_subs | op_movz | op_movk;
        // Only EQ and LT are implemented; other condition codes fall through as not taken.
        cond_true = ((instruction[4:0] == 5'b00000) & zero) |
                    ((instruction[4:0] == 5'b01011) & (negative ^ overflow));
    end

    assign cnt_last = (cnt_q == CntLast);
    assign sel_en   = (state_q == StDecode) | (state_q == StExec) |
                      (state_q == StMem) | (state_q == StWb);
    assign active   = reset & ~stall;

    always_comb begin
        pcwr_raw     = 1'b0;
        irwr_raw     = 1'b0;
        regwr_raw    = 1'b0;
        memwr_raw    = 1'b0;
        setflags_raw = 1'b0;
        brtaken_raw  = 1'b0;
        memrd_raw    = 1'b0;
        case (state_q)
            StFetch: begin
                memrd_raw = 1'b1;
                irwr_raw  = cnt_last;
            end
            StExec: begin
                setflags_raw = op_adds | op_subs;
                if (is_branch) begin
                    pcwr_raw    = 1'b1;
                    brtaken_raw = op_b | (op_bcond & cond_true) | (op_cbz & zero_alu);
                end
            end
            StMem: begin
                memrd_raw = is_load;
                if (is_store && cnt_last) begin
                    memwr_raw = 1'b1;
                    pcwr_raw  = 1'b1;
                end
            end
            StWb: begin
                regwr_raw = 1'b1;
                pcwr_raw  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        if (!stall) begin
            case (state_q)
                StFetch: begin
                    if (cnt_last) begin
                        cnt_d   = 4'd0;
                        state_d = StDecode;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StDecode: begin
                    if (!is_legal) begin
                        state_d   = StHalt;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = StExec;
                    end
                end
                StExec: begin
                    if (is_branch) begin
                        state_d = StFetch;
                    end else if (is_mem) begin
                        state_d = StMem;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = StWb;
                    end
                end
                StMem: begin
                    if (cnt_last) begin
                        cnt_d   = 4'd0;
                        state_d = is_load ? StWb : StFetch;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StWb:    state_d = StFetch;
                StHalt:  state_d = StHalt;
                default: state_d = StFetch;
            endcase
            // The final pcwr of an instruction is also its retirement.
            if (pcwr_raw) begin
                retired_d = retired_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            cnt_q     <= 4'd0;
            illegal_q <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        aluop = 3'b000;
        if (sel_en) begin
            if (op_subs) begin
                aluop = 3'b011;
            end else if (op_addi | op_adds | is_mem) begin
                aluop = 3'b010;
            end
        end
    end

    assign reg2loc  = sel_en & (op_cbz | is_store);
    assign alusrc   = sel_en & op_addi;
    assign addi     = sel_en & op_addi;
    assign byteop   = sel_en & (op_ldurb | op_sturb);
    assign mov      = sel_en & (op_movz | op_movk);
    assign movk     = sel_en & op_movk;
    assign mem2reg  = sel_en & is_load;
    assign uncondbr = sel_en & op_b;

    assign pcwr        = active & pcwr_raw;
    assign irwr        = active & irwr_raw;
    assign regwr       = active & regwr_raw;
    assign memwr       = active & memwr_raw;
    assign setflags    = active & setflags_raw;
    // The zero flag is updated in the same cycle as the full flag set.
    assign setzeroflag = active & setflags_raw;
    assign brtaken     = active & brtaken_raw;
    assign memrd       = active & memrd_raw;

    assign illegal = illegal_q;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; three instances at MEM_LAT 1, 2 and 3 share stimulus
// and one is observed at a time.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic        negative = 1'b0, overflow = 1'b0, zero = 1'b0, carry_out = 1'b0;
    logic        zero_alu = 1'b0, stall = 1'b0;
    logic [1:0]  sel = 2'd1;

    logic [2:0]  aluop_w [3];
    logic        reg2loc_w [3], alusrc_w [3], addi_w [3], byteop_w [3], mov_w [3], movk_w [3];
    logic        mem2reg_w [3], uncondbr_w [3], regwr_w [3], memwr_w [3], setflags_w [3];
    logic        setzeroflag_w [3], brtaken_w [3], pcwr_w [3], irwr_w [3], memrd_w [3];
    logic        illegal_w [3];
    logic [2:0]  state_w [3];
    logic [31:0] retired_w [3];

    logic [2:0]  aluop, state;
    logic [31:0] retired;
    logic reg2loc, alusrc, addi, byteop, mov, movk, mem2reg, uncondbr, regwr, memwr, setflags;
    logic setzeroflag, brtaken, pcwr, irwr, memrd, illegal;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_control #(.MEM_LAT(g + 1)) u_dut (
            .clk(clk), .reset(reset), .instruction(instruction), .negative(negative),
            .overflow(overflow), .zero(zero), .carry_out(carry_out), .zero_alu(zero_alu),
            .stall(stall), .aluop(aluop_w[g]), .reg2loc(reg2loc_w[g]), .alusrc(alusrc_w[g]),
            .addi(addi_w[g]), .byteop(byteop_w[g]), .mov(mov_w[g]), .movk(movk_w[g]),
            .mem2reg(mem2reg_w[g]), .uncondbr(uncondbr_w[g]), .regwr(regwr_w[g]),
            .memwr(memwr_w[g]), .setflags(setflags_w[g]), .setzeroflag(setzeroflag_w[g]),
            .brtaken(brtaken_w[g]), .pcwr(pcwr_w[g]), .irwr(irwr_w[g]), .memrd(memrd_w[g]),
            .illegal(illegal_w[g]), .state(state_w[g]), .retired(retired_w[g])
        );
    end

    assign aluop = aluop_w[sel];       assign reg2loc = reg2loc_w[sel];
    assign alusrc = alusrc_w[sel];     assign addi = addi_w[sel];
    assign byteop = byteop_w[sel];     assign mov = mov_w[sel];
    assign movk = movk_w[sel];         assign mem2reg = mem2reg_w[sel];
    assign uncondbr = uncondbr_w[sel]; assign regwr = regwr_w[sel];
    assign memwr = memwr_w[sel];       assign setflags = setflags_w[sel];
    assign setzeroflag = setzeroflag_w[sel];
    assign brtaken = brtaken_w[sel];   assign pcwr = pcwr_w[sel];
    assign irwr = irwr_w[sel];         assign memrd = memrd_w[sel];
    assign illegal = illegal_w[sel];   assign state = state_w[sel];
    assign retired = retired_w[sel];

    localparam logic [31:0] IAddi  = 32'h91001401;  // ADDI X1,X0,#5
    localparam logic [31:0] ISubs  = 32'hEB010023;  // SUBS X3,X1,X1
    localparam logic [31:0] IBeq   = 32'h54000040;
    localparam logic [31:0] IBlt   = 32'h5400004B;
    localparam logic [31:0] ICbz   = 32'hB4000041;
    localparam logic [31:0] IB     = 32'h14000004;
    localparam logic [31:0] ISturb = 32'h38000022;
    localparam logic [31:0] ILdurb = 32'h38400022;
    localparam logic [31:0] IStur  = 32'hF8000022;
    localparam logic [31:0] ILdur  = 32'hF8400022;
    localparam logic [31:0] IMovz  = 32'hD2800001;
    localparam logic [31:0] IMovk  = 32'hF2800001;

    int checks = 0, failures = 0;
    int cyc, st_start = 0, st_len = 0, n_both = 0;
    int n_pcwr, n_irwr, n_regwr, n_memwr, n_setflags, n_brtaken, n_memrd, n_stall_strobe;
    int pcwr_cyc, irwr_cyc, regwr_cyc, memwr_cyc, sf_cyc, n_wb, n_addi_stall;
    logic done, pc_br, pc_unc, pc_r2l, wr_m2r, wr_byte, wr_alusrc, wr_mov, wr_movk;
    logic mw_byte, mw_r2l;
    logic [2:0] ex_aluop;

    // Runs one instruction from its first FETCH cycle until its final pcwr (or the budget).
    task automatic run_instr(input logic [31:0] ins, input int budget);
        cyc = 0; done = 1'b0; n_pcwr = 0; n_irwr = 0; n_regwr = 0; n_memwr = 0;
        n_setflags = 0; n_brtaken = 0; n_memrd = 0; n_stall_strobe = 0; n_wb = 0;
        n_addi_stall = 0; pcwr_cyc = 0; irwr_cyc = 0; regwr_cyc = 0; memwr_cyc = 0; sf_cyc = 0;
        ex_aluop = 3'bxxx;
        instruction = ins;
        while (!done && cyc < budget) begin
            if (cyc != 0) @(negedge clk);
            cyc++;
            stall = (cyc >= st_start) && (cyc < st_start + st_len);
            #1;
            if (pcwr) begin
                n_pcwr++; pcwr_cyc = cyc; pc_br = brtaken; pc_unc = uncondbr; pc_r2l = reg2loc;
                done = 1'b1;
            end
            if (irwr) begin n_irwr++; irwr_cyc = cyc; end
            if (regwr) begin
                n_regwr++; regwr_cyc = cyc; wr_m2r = mem2reg; wr_byte = byteop;
                wr_alusrc = alusrc; wr_mov = mov; wr_movk = movk;
            end
            if (memwr) begin n_memwr++; memwr_cyc = cyc; mw_byte = byteop; mw_r2l = reg2loc; end
            if (setflags) begin n_setflags++; sf_cyc = cyc; end
            if (brtaken) n_brtaken++;
            if (memrd) n_memrd++;
            if (regwr && memwr) n_both++;
            if (stall && (pcwr | irwr | regwr | memwr | setflags | brtaken | memrd))
                n_stall_strobe++;
            if (stall && addi) n_addi_stall++;
            if (state == 3'd4) n_wb++;
            if (state == 3'd2) ex_aluop = aluop;
        end
        @(negedge clk);
        stall = 1'b0;
    endtask

    task automatic do_reset(input logic [1:0] s);
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; st_len = 0; sel = s;
        negative = 1'b0; overflow = 1'b0; zero = 1'b0; zero_alu = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        sel = 2'd1; stall = 1'b0; reset = 1'b0; instruction = IAddi;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state); end
        checks++; if ({regwr, memwr, setflags, setzeroflag, brtaken, pcwr, irwr, memrd} !== 8'd0) begin
            failures++; $display("FAIL reset_strobes got=%b want=0", {regwr, memwr, setflags, setzeroflag, brtaken, pcwr, irwr, memrd}); end
        checks++; if ({aluop, reg2loc, alusrc, addi, byteop, mov, movk, mem2reg, uncondbr} !== 11'd0) begin
            failures++; $display("FAIL reset_selects got=%b want=0", {aluop, reg2loc, alusrc, addi, byteop, mov, movk, mem2reg, uncondbr}); end
        checks++; if (retired !== 32'd0) begin failures++; $display("FAIL reset_retired got=%0d want=0", retired); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b want=0", illegal); end
    endtask

    task automatic test_addi();
        do_reset(2'd1);
        run_instr(IAddi, 50);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL addi_timeout got=%b want=1", done); end
        checks++; if (cyc !== 5) begin failures++; $display("FAIL addi_cycles got=%0d want=5", cyc); end
        checks++; if (irwr_cyc !== 2 || n_irwr !== 1) begin failures++; $display("FAIL addi_irwr cyc=%0d n=%0d want cyc=2 n=1", irwr_cyc, n_irwr); end
        checks++; if (regwr_cyc !== 5 || n_regwr !== 1) begin failures++; $display("FAIL addi_regwr cyc=%0d n=%0d want cyc=5 n=1", regwr_cyc, n_regwr); end
        checks++; if (pcwr_cyc !== 5 || n_pcwr !== 1) begin failures++; $display("FAIL addi_pcwr cyc=%0d n=%0d want cyc=5 n=1", pcwr_cyc, n_pcwr); end
        checks++; if (n_memwr !== 0 || n_setflags !== 0 || n_brtaken !== 0) begin failures++; $display("FAIL addi_extra memwr=%0d sf=%0d br=%0d want 0", n_memwr, n_setflags, n_brtaken); end
        checks++; if (ex_aluop !== 3'b010 || wr_alusrc !== 1'b1) begin failures++; $display("FAIL addi_sel aluop=%b alusrc=%b want 010 1", ex_aluop, wr_alusrc); end
        checks++; if (n_memrd !== 2) begin failures++; $display("FAIL addi_memrd got=%0d want=2", n_memrd); end
        checks++; if (retired !== 32'd1 || state !== 3'd0) begin failures++; $display("FAIL addi_retire retired=%0d state=%0d want 1 0", retired, state); end
    endtask

    task automatic test_flags_branch();
        do_reset(2'd1);
        run_instr(ISubs, 50);
        checks++; if (cyc !== 5 || regwr_cyc !== 5) begin failures++; $display("FAIL subs_cycles cyc=%0d regwr=%0d want 5 5", cyc, regwr_cyc); end
        checks++; if (n_setflags !== 1 || sf_cyc !== 4) begin failures++; $display("FAIL subs_setflags n=%0d cyc=%0d want 1 4", n_setflags, sf_cyc); end
        checks++; if (ex_aluop !== 3'b011) begin failures++; $display("FAIL subs_aluop got=%b want=011", ex_aluop); end
        zero = 1'b1;
        run_instr(IBeq, 50);
        checks++; if (cyc !== 4 || pcwr_cyc !== 4) begin failures++; $display("FAIL beq_cycles cyc=%0d pcwr=%0d want 4 4", cyc, pcwr_cyc); end
        checks++; if (pc_br !== 1'b1 || pc_unc !== 1'b0 || n_brtaken !== 1) begin failures++; $display("FAIL beq_taken br=%b unc=%b n=%0d want 1 0 1", pc_br, pc_unc, n_brtaken); end
        checks++; if (n_regwr !== 0 || n_setflags !== 0) begin failures++; $display("FAIL beq_extra regwr=%0d sf=%0d want 0 0", n_regwr, n_setflags); end
        zero = 1'b0;
        run_instr(IBeq, 50);
        checks++; if (n_brtaken !== 0 || n_pcwr !== 1) begin failures++; $display("FAIL beq_not_taken br=%0d pcwr=%0d want 0 1", n_brtaken, n_pcwr); end
        negative = 1'b1; overflow = 1'b0;
        run_instr(IBlt, 50);
        checks++; if (pc_br !== 1'b1) begin failures++; $display("FAIL blt_taken got=%b want=1", pc_br); end
        overflow = 1'b1;
        run_instr(IBlt, 50);
        checks++; if (n_brtaken !== 0 || cyc !== 4) begin failures++; $display("FAIL blt_not_taken br=%0d cyc=%0d want 0 4", n_brtaken, cyc); end
        checks++; if (retired !== 32'd5) begin failures++; $display("FAIL b2b_retired got=%0d want=5", retired); end
    endtask

    task automatic test_byte_mem();
        do_reset(2'd2);
        run_instr(ISturb, 50);
        checks++; if (cyc !== 8 || pcwr_cyc !== 8) begin failures++; $display("FAIL sturb_cycles cyc=%0d pcwr=%0d want 8 8", cyc, pcwr_cyc); end
        checks++; if (memwr_cyc !== 8 || n_memwr !== 1) begin failures++; $display("FAIL sturb_memwr cyc=%0d n=%0d want 8 1", memwr_cyc, n_memwr); end
        checks++; if (mw_byte !== 1'b1 || mw_r2l !== 1'b1) begin failures++; $display("FAIL sturb_sel byte=%b r2l=%b want 1 1", mw_byte, mw_r2l); end
        checks++; if (n_regwr !== 0 || n_memrd !== 3) begin failures++; $display("FAIL sturb_extra regwr=%0d memrd=%0d want 0 3", n_regwr, n_memrd); end
        run_instr(ILdurb, 50);
        checks++; if (cyc !== 9 || regwr_cyc !== 9 || n_regwr !== 1) begin failures++; $display("FAIL ldurb_cycles cyc=%0d regwr=%0d n=%0d want 9 9 1", cyc, regwr_cyc, n_regwr); end
        checks++; if (wr_m2r !== 1'b1 || wr_byte !== 1'b1) begin failures++; $display("FAIL ldurb_sel m2r=%b byte=%b want 1 1", wr_m2r, wr_byte); end
        checks++; if (n_memwr !== 0 || n_memrd !== 6 || ex_aluop !== 3'b010) begin failures++; $display("FAIL ldurb_mem memwr=%0d memrd=%0d aluop=%b want 0 6 010", n_memwr, n_memrd, ex_aluop); end
        checks++; if (retired !== 32'd2) begin failures++; $display("FAIL mem_retired got=%0d want=2", retired); end
    endtask

    task automatic test_cbz();
        do_reset(2'd1);
        zero_alu = 1'b0;
        run_instr(ICbz, 50);
        checks++; if (n_brtaken !== 0 || n_pcwr !== 1 || pcwr_cyc !== 4) begin failures++; $display("FAIL cbz_nz br=%0d pcwr=%0d cyc=%0d want 0 1 4", n_brtaken, n_pcwr, pcwr_cyc); end
        checks++; if (pc_r2l !== 1'b1 || ex_aluop !== 3'b000) begin failures++; $display("FAIL cbz_sel r2l=%b aluop=%b want 1 000", pc_r2l, ex_aluop); end
        zero_alu = 1'b1;
        run_instr(ICbz, 50);
        checks++; if (pc_br !== 1'b1 || n_brtaken !== 1) begin failures++; $display("FAIL cbz_z br=%b n=%0d want 1 1", pc_br, n_brtaken); end
        zero_alu = 1'b0;
    endtask

    task automatic test_illegal();
        int bad_strobe, bad_state;
        do_reset(2'd1);
        run_instr(IAddi, 50);
        run_instr(32'h0000_0000, 3);
        checks++; if (done !== 1'b0 || n_irwr !== 1) begin failures++; $display("FAIL ill_decode done=%b irwr=%0d want 0 1", done, n_irwr); end
        bad_strobe = 0; bad_state = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (pcwr | irwr | regwr | memwr | setflags | setzeroflag | brtaken | memrd) bad_strobe++;
            if (state !== 3'd7 || illegal !== 1'b1) bad_state++;
            @(negedge clk);
        end
        checks++; if (bad_strobe !== 0) begin failures++; $display("FAIL ill_strobes got=%0d want=0", bad_strobe); end
        checks++; if (bad_state !== 0) begin failures++; $display("FAIL ill_halt bad_cycles=%0d want=0", bad_state); end
        checks++; if (retired !== 32'd1) begin failures++; $display("FAIL ill_retired got=%0d want=1", retired); end
        do_reset(2'd1);
        #1;
        checks++; if (illegal !== 1'b0 || state !== 3'd0) begin failures++; $display("FAIL ill_clear ill=%b state=%0d want 0 0", illegal, state); end
    endtask

    task automatic test_stall();
        do_reset(2'd1);
        st_start = 5; st_len = 3;
        run_instr(IAddi, 50);
        checks++; if (cyc !== 8 || regwr_cyc !== 8 || n_regwr !== 1) begin failures++; $display("FAIL stall_wb cyc=%0d regwr=%0d n=%0d want 8 8 1", cyc, regwr_cyc, n_regwr); end
        checks++; if (n_stall_strobe !== 0 || n_pcwr !== 1) begin failures++; $display("FAIL stall_suppress strobes=%0d pcwr=%0d want 0 1", n_stall_strobe, n_pcwr); end
        checks++; if (n_wb !== 4 || n_addi_stall !== 3) begin failures++; $display("FAIL stall_hold wb=%0d addi=%0d want 4 3", n_wb, n_addi_stall); end
        st_start = 2; st_len = 2;
        run_instr(IAddi, 50);
        checks++; if (cyc !== 7 || irwr_cyc !== 4 || n_irwr !== 1) begin failures++; $display("FAIL stall_fetch cyc=%0d irwr=%0d n=%0d want 7 4 1", cyc, irwr_cyc, n_irwr); end
        st_len = 0;
        checks++; if (retired !== 32'd2) begin failures++; $display("FAIL stall_retired got=%0d want=2", retired); end
    endtask

    task automatic test_reset_mid_store();
        logic [2:0] st_before;
        int n_mw;
        do_reset(2'd1);
        run_instr(IStur, 4);
        st_before = state;
        n_mw = n_memwr;
        reset = 1'b0;
        #1;
        if (memwr) n_mw++;
        checks++; if (st_before !== 3'd3) begin failures++; $display("FAIL rst_mem_state got=%0d want=3", st_before); end
        checks++; if (state !== 3'd0 || retired !== 32'd0 || memrd !== 1'b0) begin failures++; $display("FAIL rst_mem_abort state=%0d retired=%0d memrd=%b want 0 0 0", state, retired, memrd); end
        repeat (2) begin
            @(negedge clk);
            #1;
            if (memwr) n_mw++;
        end
        @(negedge clk);
        reset = 1'b1;
        checks++; if (n_mw !== 0) begin failures++; $display("FAIL rst_mem_memwr got=%0d want=0", n_mw); end
        run_instr(IAddi, 50);
        checks++; if (cyc !== 5 || irwr_cyc !== 2 || retired !== 32'd1) begin failures++; $display("FAIL rst_restart cyc=%0d irwr=%0d retired=%0d want 5 2 1", cyc, irwr_cyc, retired); end
    endtask

    task automatic test_lat1();
        do_reset(2'd0);
        run_instr(IAddi, 50);
        checks++; if (cyc !== 4 || irwr_cyc !== 1 || regwr_cyc !== 4) begin failures++; $display("FAIL lat1_addi cyc=%0d irwr=%0d regwr=%0d want 4 1 4", cyc, irwr_cyc, regwr_cyc); end
        run_instr(IB, 50);
        checks++; if (cyc !== 3 || pc_unc !== 1'b1 || pc_br !== 1'b1) begin failures++; $display("FAIL lat1_b cyc=%0d unc=%b br=%b want 3 1 1", cyc, pc_unc, pc_br); end
        run_instr(ILdur, 50);
        checks++; if (cyc !== 5 || regwr_cyc !== 5 || n_memrd !== 2 || wr_byte !== 1'b0) begin failures++; $display("FAIL lat1_ldur cyc=%0d regwr=%0d memrd=%0d byte=%b want 5 5 2 0", cyc, regwr_cyc, n_memrd, wr_byte); end
        run_instr(IStur, 50);
        checks++; if (cyc !== 4 || memwr_cyc !== 4 || n_memwr !== 1) begin failures++; $display("FAIL lat1_stur cyc=%0d memwr=%0d n=%0d want 4 4 1", cyc, memwr_cyc, n_memwr); end
        run_instr(IMovz, 50);
        checks++; if (cyc !== 4 || wr_mov !== 1'b1 || wr_movk !== 1'b0) begin failures++; $display("FAIL lat1_movz cyc=%0d mov=%b movk=%b want 4 1 0", cyc, wr_mov, wr_movk); end
        run_instr(IMovk, 50);
        checks++; if (wr_mov !== 1'b1 || wr_movk !== 1'b1 || ex_aluop !== 3'b000) begin failures++; $display("FAIL lat1_movk mov=%b movk=%b aluop=%b want 1 1 000", wr_mov, wr_movk, ex_aluop); end
        checks++; if (retired !== 32'd6) begin failures++; $display("FAIL lat1_retired got=%0d want=6", retired); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_flags_branch();
        test_byte_mem();
        test_cbz();
        test_illegal();
        test_stall();
        test_reset_mid_store();
        test_lat1();
        checks++; if (n_both !== 0) begin failures++; $display("FAIL regwr_memwr_overlap got=%0d want=0", n_both); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the CPU datapath. It replaces the single-cycle "every signal every cycle" operation with a state machine: FETCH, DECODE, EXEC, MEM, WB. Instruction and data memory are given a programmable latency. Write strobes (PC, instruction register, register file, memory, flags) are issued exactly once per instruction. It sits beside the datapath, reads the latched instruction and condition flags, and drives every datapath control input.

## Interface
- MEM_LAT, 2, cycles each instruction fetch or data access occupies (legal 1..15)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- instruction  in  32  instruction-register output, stable from DECODE until the next FETCH
- negative, overflow, zero, carry_out  in  1 each  registered condition flags
- zero_alu  in  1  combinational ALU zero (CBZ)
- stall  in  1  freezes state and counters while 1; all strobes forced 0
- aluop  out  3  000 pass B, 010 add, 011 sub
- reg2loc, alusrc, addi, byteop, mov, movk, mem2reg, uncondbr  out  1 each  datapath selects (level, valid DECODE through end of instruction)
- regwr, memwr, setflags, setzeroflag, brtaken  out  1 each  datapath strobes
- pcwr  out  1  PC write enable, one cycle per instruction
- irwr  out  1  instruction-register load, one cycle per instruction
- memrd  out  1  memory read request, high for every FETCH and load-MEM cycle
- illegal  out  1  sticky, set on undecodable opcode
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7
- retired  out  32  count of completed instructions, wraps 0xFFFFFFFF→0

## Operation
Decode classes and their opcodes:
- B: [31:26]=000101
- B.cond: [31:24]=01010100; EQ=00000 uses zero, LT=01011 uses negative≠overflow
- CBZ: [31:24]=10110100
- ADDI: [31:22]=1001000100
- ADDS: [31:21]=10101011000
- SUBS: [31:21]=11101011000
- LDUR/STUR: [31:21]=11111000010/11111000000
- LDURB/STURB: [31:21]=00111000010/00111000000
- MOVZ/MOVK: [31:23]=110100101/111100101
- Any other opcode: illegal

State machine:
- FETCH: memrd=1; a wait counter runs 0..MEM_LAT-1; irwr=1 on the last count; then → DECODE.
- DECODE: drives select levels and makes no write. Illegal → HALT with illegal=1; otherwise → EXEC.
- EXEC, ALU and MOV classes: ADDS/SUBS assert setflags (one cycle); then → WB.
- EXEC, LDUR/STUR/LDURB/STURB: aluop=010, alusrc=0, byteop per the B variants; → MEM.
- EXEC, branches:
  - B: uncondbr=1, brtaken=1.
  - B.cond: brtaken is the condition on the registered flags.
  - CBZ: reg2loc=1, aluop=000, brtaken=zero_alu.
  - All branches assert pcwr and retire, then → FETCH.
- MEM: the counter runs 0..MEM_LAT-1.
  - Load: memrd=1; → WB after the last count.
  - Store: reg2loc=1; on the last count memwr=1 and pcwr=1, retire, → FETCH.
- WB: regwr=1, pcwr=1 (brtaken=0, so PC+4); mem2reg=1 for loads; retire; → FETCH.
- HALT: all strobes 0; exit only via reset.

General rules:
- Strobes are Moore outputs decoded from state, counter and latched opcode. Selects are decoded from instruction.

## Timing
- While reset=0: state=FETCH, counter=0, retired=0, illegal=0, every output 0. Reset asserted mid-instruction aborts it with no further strobe.
- Cycles per instruction:
  - ALU/MOV: MEM_LAT+3
  - Load: 2·MEM_LAT+3
  - Store: 2·MEM_LAT+2
  - Branch: MEM_LAT+2
- pcwr, irwr, regwr, memwr and setflags are each high for at most one cycle per instruction. regwr and memwr are never high together.
- stall=1 holds state and counter unchanged, forces strobes to 0, and leaves selects held. When stall falls, the strobe due in that cycle fires then.
- stall arriving on the same edge as a strobe cycle suppresses that strobe; it fires after stall is released.
- MEM_LAT=1: the counter is always 0; FETCH and MEM are single cycles.
- retired increments on the same edge as the final pcwr.

## Test plan
- Reset release, MEM_LAT=2, ADDI X1,X0,#5: irwr at cycle 2, regwr+pcwr at cycle 5 only, retired=1, state back to FETCH.
- SUBS then B.EQ with equal operands: setflags exactly one cycle in SUBS EXEC. B.EQ EXEC shows brtaken=1, uncondbr=0, pcwr=1. Branch total is 4 cycles.
- STURB then LDURB, MEM_LAT=3:
  - STURB: memwr=1, byteop=1 on the 3rd MEM cycle; total 8 cycles.
  - LDURB: regwr with mem2reg=1, byteop=1; total 9 cycles.
- CBZ with zero_alu=0 → brtaken=0, pcwr=1. Opcode 0x00000000 → HALT, illegal=1, no strobes for 20 cycles, retired unchanged.
- stall=1 for 3 cycles placed on the WB cycle: regwr is suppressed, then fires once on release; the instruction takes 3 extra cycles.
- reset pulsed low during MEM of a store: memwr never asserts, retired=0, and execution restarts at FETCH.
